pn_gen_checker: RTL and testbench
=================================

// Module: pn_gen_checker
// PURPOSE
//  Parallel PN (PRBS) pattern generator plus self-synchronising checker, DW bits per clock, any LFSR set by POL_MASK/POL_W.
//  Generator drives link/loopback test traffic, with single-bit error injection.
//  Checker hunts for lock on incoming words, declares lock/loss-of-lock, and counts errored words and bits.
//  Sits between the test-pattern control registers and the datapath under test.
// PARAMETERS
//  POL_MASK    8'hC0  tap mask over a POL_W+1 window; bit 0 (self) must be 0
//  POL_W       7      LFSR order (state width)
//  DW          16     bits per word
//  SEED        7'h7F  generator state after reset (POL_W bits)
//  LOCK_CNT    4      consecutive clean words needed to lock (>=1)
//  UNLOCK_CNT  4      consecutive errored words needed to drop lock (>=1)
//  CNT_W       32     error counter width
// PORTS
//  clk           in   1        clock
//  rst           in   1        asynchronous reset, active-high
//  gen_load      in   1        load gen_seed into the generator state
//  gen_seed      in   POL_W    seed value
//  gen_en        in   1        produce one word
//  inj_err       in   1        flip bit 0 of the word produced this cycle
//  gen_valid     out  1        gen_data valid
//  gen_data      out  DW       generated word
//  in_valid      in   1        in_data valid
//  in_data       in   DW       received word
//  clr_cnt       in   1        synchronous clear of error counters
//  chk_valid     out  1        chk_err_bits valid
//  chk_err_bits  out  DW       per-bit mismatch of the checked word
//  locked        out  1        checker in LOCKED
//  err_word_cnt  out  CNT_W    errored words counted while locked (saturating)
//  err_bit_cnt   out  CNT_W    errored bits counted while locked (saturating)
// BEHAVIOUR
//  PN function: f(s) = word pn, full = {s[POL_W-1:0], pn}, pn[i] = ^(full[i +: POL_W+1] & POL_MASK), computed recursively from MSB down.
//  Successor state is pn[POL_W-1:0].
//  Reset: gen state=SEED; all outputs 0; checker FSM in EMPTY; counters 0.
//  Generator:
//   - gen_load has priority over gen_en in the same cycle: state<=gen_seed, no word produced.
//   - gen_en: gen_data<=f(state)^{inj_err at bit 0}, gen_valid<=1 next cycle, state<=f(state)[POL_W-1:0]. Injected errors never corrupt state.
//   - gen_en low: gen_valid<=0; gen_data holds.
//   - Seed 0 yields an all-zero stream; no protection.
//  Checker expected word: exp[i] = ^({prev, in_data}[i +: POL_W+1] & POL_MASK), using received bits (self-sync).
//   - err = in_data ^ exp; prev <= in_data[POL_W-1:0] on every in_valid, errored or not.
//   - Outputs: chk_valid/chk_err_bits registered, 1 cycle after in_valid, in HUNT and LOCKED; chk_valid=0 in EMPTY.
//  FSM:
//   - EMPTY: first in_valid only captures prev -> HUNT, good=0.
//   - HUNT: word clean AND in_data!=0 -> good++, else good=0. good reaches LOCK_CNT -> LOCKED, bad=0; locked=1 the cycle after that word.
//   - LOCKED: err!=0 -> bad++, else bad=0. bad reaches UNLOCK_CNT -> HUNT, good=0; locked=0 next cycle.
//  Counters:
//   - Update only for words checked in LOCKED, including the word that causes unlock.
//   - err_word_cnt += (err!=0); err_bit_cnt += popcount(err). Both saturate at all-ones, no wrap.
//   - clr_cnt zeroes both and wins over a same-cycle increment (that word is dropped).
//  in_valid low: no state change. rst mid-stream returns everything to reset values immediately.
//  Error multiplication: one flipped received bit gives 1 + popcount(POL_MASK) error bits over <=2 words.
// TESTING
//  - Loopback gen->chk, SEED=7'h7F, gen_en continuous: locked rises at in-word 1+LOCK_CNT (=5th); counters stay 0 for 1000 words.
//  - Locked, inj_err on one word: err bit0 in that word, bits 9 and 10 next word; err_word_cnt=2, err_bit_cnt=3; locked stays 1.
//  - Locked, in_data forced to random for 4 words: locked drops after 4th; err_word_cnt=4. Restore PN: relock after 4 clean words.
//  - All-zero in_data stream: never locks, counters stay 0.
//  - err counters preset near max (CNT_W=4 build): saturate at 15; clr_cnt with same-cycle error -> 0.
//  - rst asserted mid-lock: locked, gen_valid, chk_valid, counters 0 same cycle; gen restarts from SEED; gen_load+gen_en same cycle -> no gen_valid.

Source files
------------

// File: rtl/pn_gen_checker.sv
// pn_gen_checker: parallel PRBS generator with single-bit error injection,
// plus a self-synchronising checker that hunts for lock and counts
// errored words and errored bits while locked.
module pn_gen_checker #(
    parameter int               POL_W      = 7,
    parameter logic [POL_W:0]   POL_MASK   = 8'hC0,
    parameter int               DW         = 16,
    parameter logic [POL_W-1:0] SEED       = 7'h7F,
    parameter int               LOCK_CNT   = 4,
    parameter int               UNLOCK_CNT = 4,
    parameter int               CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_gen_load,
    input  logic [POL_W-1:0] i_gen_seed,
    input  logic             i_gen_en,
    input  logic             i_inj_err,
    output logic             o_gen_valid,
    output logic [DW-1:0]    o_gen_data,
    input  logic             i_in_valid,
    input  logic [DW-1:0]    i_in_data,
    input  logic             i_clr_cnt,
    output logic             o_chk_valid,
    output logic [DW-1:0]    o_chk_err_bits,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_err_word_cnt,
    output logic [CNT_W-1:0] o_err_bit_cnt
);

    localparam int FW  = POL_W + DW;
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam int UCW = $clog2(UNLOCK_CNT + 1);
    localparam int PCW = $clog2(DW + 1);
    localparam int SW  = ((CNT_W > PCW) ? CNT_W : PCW) + 1;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } chkState_t;

    // Next PN word from a state; lower bits depend on the ones just computed,
    // so the window is filled from the MSB downwards.
    function automatic logic [DW-1:0] pnWord(input logic [POL_W-1:0] s);
        logic [FW-1:0] full;
        full = {s, {DW{1'b0}}};
        for (int i = DW - 1; i >= 0; i--) begin
            full[i] = ^(full[i +: POL_W+1] & POL_MASK);
        end
        return full[DW-1:0];
    endfunction

    // Expected word predicted purely from received bits (self-synchronising).
    function automatic logic [DW-1:0] expWord(input logic [POL_W-1:0] p,
                                              input logic [DW-1:0]    d);
        logic [FW-1:0] full;
        logic [DW-1:0] e;
        full = {p, d};
        e    = '0;
        for (int i = 0; i < DW; i++) begin
            e[i] = ^(full[i +: POL_W+1] & POL_MASK);
        end
        return e;
    endfunction

    function automatic logic [PCW-1:0] popCount(input logic [DW-1:0] v);
        logic [PCW-1:0] n;
        n = '0;
        for (int i = 0; i < DW; i++) begin
            n = n + PCW'(v[i]);
        end
        return n;
    endfunction

    logic [POL_W-1:0] r_genState;
    logic             r_genValid;
    logic [DW-1:0]    r_genData;
    logic [POL_W-1:0] r_prev;
    logic             r_chkValid;
    logic [DW-1:0]    r_chkErrBits;
    chkState_t        r_state;
    logic [LCW-1:0]   r_goodCnt;
    logic [UCW-1:0]   r_badCnt;
    logic [CNT_W-1:0] r_errWordCnt;
    logic [CNT_W-1:0] r_errBitCnt;

    logic [DW-1:0]    w_genPn;
    logic [DW-1:0]    w_err;
    logic             w_errAny;
    logic [PCW-1:0]   w_errPop;
    logic [SW-1:0]    w_bitSum;
    logic [CNT_W-1:0] w_bitSat;
    chkState_t        w_stateNext;
    logic [LCW-1:0]   w_goodNext;
    logic [UCW-1:0]   w_badNext;
    logic             w_countWord;

    assign w_genPn  = pnWord(r_genState);
    assign w_err    = i_in_data ^ expWord(r_prev, i_in_data);
    assign w_errAny = |w_err;
    assign w_errPop = popCount(w_err);
    assign w_bitSum = SW'(r_errBitCnt) + SW'(w_errPop);
    assign w_bitSat = (w_bitSum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : w_bitSum[CNT_W-1:0];

    // Generator: load beats enable; injected error only touches the output word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_genState <= SEED;
            r_genValid <= 1'b0;
            r_genData  <= '0;
        end else if (i_gen_load) begin
            r_genState <= i_gen_seed;
            r_genValid <= 1'b0;
        end else if (i_gen_en) begin
            r_genData  <= w_genPn ^ {{(DW-1){1'b0}}, i_inj_err};
            r_genValid <= 1'b1;
            r_genState <= w_genPn[POL_W-1:0];
        end else begin
            r_genValid <= 1'b0;
        end
    end

    // Lock FSM next-state: count clean non-zero words to lock, errored words to unlock.
    always_comb begin
        w_stateNext = r_state;
        w_goodNext  = r_goodCnt;
        w_badNext   = r_badCnt;
        w_countWord = 1'b0;
        if (i_in_valid) begin
            case (r_state)
                ST_EMPTY: begin
                    w_stateNext = ST_HUNT;
                    w_goodNext  = '0;
                end
                ST_HUNT: begin
                    if (!w_errAny && (i_in_data != '0)) begin
                        if (r_goodCnt == LCW'(LOCK_CNT - 1)) begin
                            w_stateNext = ST_LOCKED;
                            w_badNext   = '0;
                        end else begin
                            w_goodNext = r_goodCnt + LCW'(1);
                        end
                    end else begin
                        w_goodNext = '0;
                    end
                end
                ST_LOCKED: begin
                    w_countWord = 1'b1;
                    if (w_errAny) begin
                        if (r_badCnt == UCW'(UNLOCK_CNT - 1)) begin
                            w_stateNext = ST_HUNT;
                            w_goodNext  = '0;
                        end else begin
                            w_badNext = r_badCnt + UCW'(1);
                        end
                    end else begin
                        w_badNext = '0;
                    end
                end
                default: begin
                    w_stateNext = ST_EMPTY;
                end
            endcase
        end
    end

    // Lock FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_EMPTY;
            r_goodCnt <= '0;
            r_badCnt  <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_goodCnt <= w_goodNext;
            r_badCnt  <= w_badNext;
        end
    end

    // Checker datapath: history always follows the received stream; results only outside EMPTY.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev       <= '0;
            r_chkValid   <= 1'b0;
            r_chkErrBits <= '0;
        end else begin
            r_chkValid <= i_in_valid && (r_state != ST_EMPTY);
            if (i_in_valid) begin
                r_prev <= i_in_data[POL_W-1:0];
                if (r_state != ST_EMPTY) begin
                    r_chkErrBits <= w_err;
                end
            end
        end
    end

    // Saturating error counters; a clear drops any same-cycle increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_errWordCnt <= '0;
            r_errBitCnt  <= '0;
        end else if (i_clr_cnt) begin
            r_errWordCnt <= '0;
            r_errBitCnt  <= '0;
        end else if (w_countWord && w_errAny) begin
            if (r_errWordCnt != {CNT_W{1'b1}}) begin
                r_errWordCnt <= r_errWordCnt + CNT_W'(1);
            end
            r_errBitCnt <= w_bitSat;
        end
    end

    assign o_gen_valid    = r_genValid;
    assign o_gen_data     = r_genData;
    assign o_chk_valid    = r_chkValid;
    assign o_chk_err_bits = r_chkErrBits;
    assign o_locked       = (r_state == ST_LOCKED);
    assign o_err_word_cnt = r_errWordCnt;
    assign o_err_bit_cnt  = r_errBitCnt;

endmodule

// File: tb/tb_pn_gen_checker.sv
// Bench for pn_gen_checker: two instances (32-bit and 4-bit counters) driven
// in parallel, compared every cycle against a serial-bitstream reference model.
module tb_pn_gen_checker;

    localparam int         POL_W      = 7;
    localparam int         DW         = 16;
    localparam logic [7:0] POL_MASK   = 8'hC0;
    localparam logic [6:0] SEED       = 7'h7F;
    localparam int         LOCK_CNT   = 4;
    localparam int         UNLOCK_CNT = 4;
    localparam longint     MAX32      = 64'hFFFF_FFFF;
    localparam longint     MAX4       = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             genLoad = 1'b0;
    logic [POL_W-1:0] genSeed = '0;
    logic             genEn = 1'b0;
    logic             injErr = 1'b0;
    logic             inValid = 1'b0;
    logic [DW-1:0]    inData = '0;
    logic             clrCnt = 1'b0;

    logic             genValid, sGenValid;
    logic [DW-1:0]    genData, sGenData;
    logic             chkValid, sChkValid;
    logic [DW-1:0]    chkErrBits, sChkErrBits;
    logic             locked, sLocked;
    logic [31:0]      errWordCnt, errBitCnt;
    logic [3:0]       sErrWordCnt, sErrBitCnt;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state
    logic [POL_W-1:0] mGenState;
    bit               mGenValid;
    logic [DW-1:0]    mGenData;
    bit               chkHist[$];
    int               mChk;
    int               mGood, mBad;
    bit               mChkValid;
    logic [DW-1:0]    mErrBits;
    longint           mW32, mB32, mW4, mB4;

    pn_gen_checker #(.POL_W(POL_W), .POL_MASK(POL_MASK), .DW(DW), .SEED(SEED),
                     .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_gen_load(genLoad), .i_gen_seed(genSeed),
        .i_gen_en(genEn), .i_inj_err(injErr), .o_gen_valid(genValid), .o_gen_data(genData),
        .i_in_valid(inValid), .i_in_data(inData), .i_clr_cnt(clrCnt),
        .o_chk_valid(chkValid), .o_chk_err_bits(chkErrBits), .o_locked(locked),
        .o_err_word_cnt(errWordCnt), .o_err_bit_cnt(errBitCnt));

    pn_gen_checker #(.POL_W(POL_W), .POL_MASK(POL_MASK), .DW(DW), .SEED(SEED),
                     .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(4)) dutSmall (
        .i_clk(clk), .i_rst(rst), .i_gen_load(genLoad), .i_gen_seed(genSeed),
        .i_gen_en(genEn), .i_inj_err(injErr), .o_gen_valid(sGenValid), .o_gen_data(sGenData),
        .i_in_valid(inValid), .i_in_data(inData), .i_clr_cnt(clrCnt),
        .o_chk_valid(sChkValid), .o_chk_err_bits(sChkErrBits), .o_locked(sLocked),
        .o_err_word_cnt(sErrWordCnt), .o_err_bit_cnt(sErrBitCnt));

    // 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Serial LFSR: each new bit is the XOR of the tapped older bits; word is emitted MSB first
    function automatic logic [DW-1:0] refPnWord(input logic [POL_W-1:0] st,
                                                output logic [POL_W-1:0] nxt);
        bit h[$];
        bit b;
        logic [DW-1:0] w;
        w = '0;
        for (int j = 0; j < POL_W; j++) h.push_back(st[j]);
        for (int n = 0; n < DW; n++) begin
            b = 1'b0;
            for (int k = 1; k <= POL_W; k++) if (POL_MASK[k]) b ^= h[k-1];
            h.push_front(b);
            w[DW-1-n] = b;
        end
        for (int j = 0; j < POL_W; j++) nxt[j] = h[j];
        return w;
    endfunction

    // Predict each received bit from the previously received bits and flag differences
    function automatic logic [DW-1:0] refErrOf(input logic [DW-1:0] d);
        bit h[$];
        bit x;
        logic [DW-1:0] e;
        h = chkHist;
        e = '0;
        for (int n = 0; n < DW; n++) begin
            x = 1'b0;
            for (int k = 1; k <= POL_W; k++) if (POL_MASK[k]) x ^= h[k-1];
            e[DW-1-n] = d[DW-1-n] ^ x;
            h.push_front(d[DW-1-n]);
        end
        return e;
    endfunction

    task automatic refPush(input logic [DW-1:0] d);
        for (int n = 0; n < DW; n++) chkHist.push_front(d[DW-1-n]);
        while (chkHist.size() > POL_W) void'(chkHist.pop_back());
    endtask

    task automatic modelReset();
        mGenState = SEED;
        mGenValid = 1'b0;
        mGenData  = '0;
        chkHist.delete();
        for (int j = 0; j < POL_W; j++) chkHist.push_back(1'b0);
        mChk = 0; mGood = 0; mBad = 0;
        mChkValid = 1'b0;
        mErrBits  = '0;
        mW32 = 0; mB32 = 0; mW4 = 0; mB4 = 0;
    endtask

    // Advance the model by one clock edge using the inputs applied for that edge
    task automatic modelStep(input bit load, input logic [POL_W-1:0] seed, input bit en,
                             input bit inj, input bit inV, input logic [DW-1:0] d, input bit clr);
        logic [DW-1:0]    w, e;
        logic [POL_W-1:0] nxt;
        int               pop;
        if (load) begin
            mGenState = seed;
            mGenValid = 1'b0;
        end else if (en) begin
            w = refPnWord(mGenState, nxt);
            mGenData  = w ^ {{(DW-1){1'b0}}, inj};
            mGenValid = 1'b1;
            mGenState = nxt;
        end else begin
            mGenValid = 1'b0;
        end
        if (inV) begin
            e = refErrOf(d);
            refPush(d);
            if (mChk == 0) begin
                mChk = 1; mGood = 0; mChkValid = 1'b0;
            end else begin
                mChkValid = 1'b1;
                mErrBits  = e;
                if (mChk == 1) begin
                    if (e == 0 && d != 0) begin
                        mGood++;
                        if (mGood == LOCK_CNT) begin mChk = 2; mBad = 0; end
                    end else mGood = 0;
                end else begin
                    if (e != 0) begin
                        pop  = $countones(e);
                        mW32 = (mW32 < MAX32) ? mW32 + 1 : MAX32;
                        mB32 = (mB32 + pop < MAX32) ? mB32 + pop : MAX32;
                        mW4  = (mW4 < MAX4) ? mW4 + 1 : MAX4;
                        mB4  = (mB4 + pop < MAX4) ? mB4 + pop : MAX4;
                        mBad++;
                        if (mBad == UNLOCK_CNT) begin mChk = 1; mGood = 0; end
                    end else mBad = 0;
                end
            end
        end else begin
            mChkValid = 1'b0;
        end
        if (clr) begin
            mW32 = 0; mB32 = 0; mW4 = 0; mB4 = 0;
        end
    endtask

    // Compare every observable output of both instances against the model
    task automatic compareAll();
        checkOutput("gen_valid", genValid, mGenValid);
        checkOutput("gen_data", genData, mGenData);
        checkOutput("chk_valid", chkValid, mChkValid);
        checkOutput("chk_err_bits", chkErrBits, mErrBits);
        checkOutput("locked", locked, (mChk == 2));
        checkOutput("err_word_cnt", errWordCnt, mW32);
        checkOutput("err_bit_cnt", errBitCnt, mB32);
        checkOutput("small_locked", sLocked, (mChk == 2));
        checkOutput("small_err_word_cnt", sErrWordCnt, mW4);
        checkOutput("small_err_bit_cnt", sErrBitCnt, mB4);
    endtask

    // Drive one cycle of inputs, clock it, then check a little after the edge
    task automatic applyStimulus(input bit load, input logic [POL_W-1:0] seed, input bit en,
                                 input bit inj, input bit inV, input logic [DW-1:0] d, input bit clr);
        genLoad = load; genSeed = seed; genEn = en; injErr = inj;
        inValid = inV;  inData  = d;    clrCnt = clr;
        @(posedge clk);
        #1;
        modelStep(load, seed, en, inj, inV, d, clr);
        compareAll();
    endtask

    // Loopback cycle: feed the word the generator currently presents, optionally replaced by noise
    task automatic loopCycle(input bit inj, input bit clr, input bit corrupt);
        logic [DW-1:0] d;
        d = mGenData;
        if (corrupt) begin
            d = 16'($urandom);
            for (int t = 0; t < 100 && refErrOf(d) == 0; t++) d = 16'($urandom);
        end
        applyStimulus(1'b0, '0, 1'b1, inj, mGenValid, d, clr);
    endtask

    // Assert reset between clock edges and check that it takes effect without a clock
    task automatic doReset();
        #3;
        rst = 1'b1;
        #1;
        modelReset();
        compareAll();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compareAll();
    endtask

    // Watchdog so the run can never hang
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int wordsFed;
        int lockWord;
        bit v;

        modelReset();
        doReset();

        // Loopback from SEED: lock on the 5th received word, then 1000 clean words
        wordsFed = 0;
        lockWord = 0;
        for (int i = 0; i < 1100 && wordsFed < 1000; i++) begin
            v = mGenValid;
            loopCycle(1'b0, 1'b0, 1'b0);
            if (v) wordsFed++;
            if (lockWord == 0 && locked) lockWord = wordsFed;
        end
        checkOutput("lock_word_index", lockWord, 1 + LOCK_CNT);
        checkOutput("clean_word_cnt", errWordCnt, 0);
        checkOutput("clean_bit_cnt", errBitCnt, 0);

        // Single injected error: bit 0 now, bits 9 and 10 in the following word
        loopCycle(1'b1, 1'b0, 1'b0);
        loopCycle(1'b0, 1'b0, 1'b0);
        checkOutput("inj_err_bits", chkErrBits, 16'h0001);
        loopCycle(1'b0, 1'b0, 1'b0);
        checkOutput("inj_echo_bits", chkErrBits, 16'h0600);
        for (int i = 0; i < 3; i++) loopCycle(1'b0, 1'b0, 1'b0);
        checkOutput("inj_word_cnt", errWordCnt, 2);
        checkOutput("inj_bit_cnt", errBitCnt, 3);
        checkOutput("inj_still_locked", locked, 1);

        // Four noise words drop lock; clean stream relocks
        loopCycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) loopCycle(1'b0, 1'b0, 1'b1);
        checkOutput("noise3_locked", locked, 1);
        loopCycle(1'b0, 1'b0, 1'b1);
        checkOutput("noise4_unlocked", locked, 0);
        checkOutput("noise_word_cnt", errWordCnt, 4);
        for (int i = 0; i < 5; i++) loopCycle(1'b0, 1'b0, 1'b0);
        checkOutput("relocked", locked, 1);

        // Repeated injections saturate the 4-bit counters without losing lock
        for (int i = 0; i < 12; i++) begin
            loopCycle(1'b1, 1'b0, 1'b0);
            loopCycle(1'b0, 1'b0, 1'b0);
            loopCycle(1'b0, 1'b0, 1'b0);
        end
        checkOutput("sat_word_cnt4", sErrWordCnt, 15);
        checkOutput("sat_bit_cnt4", sErrBitCnt, 15);
        checkOutput("sat_locked", locked, 1);
        // Clear on the same cycle as an errored word leaves zero
        loopCycle(1'b1, 1'b0, 1'b0);
        loopCycle(1'b0, 1'b1, 1'b0);
        checkOutput("clr_word_cnt4", sErrWordCnt, 0);
        checkOutput("clr_bit_cnt4", sErrBitCnt, 0);
        checkOutput("clr_word_cnt", errWordCnt, 0);
        loopCycle(1'b0, 1'b0, 1'b0);
        checkOutput("post_clr_word_cnt", errWordCnt, 1);
        checkOutput("post_clr_bit_cnt", errBitCnt, 2);

        // Reset in the middle of lock, then restart from SEED and try load+enable together
        doReset();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 7'h55, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("load_en_no_valid", genValid, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);

        // All-zero received stream never locks
        doReset();
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        checkOutput("zero_stream_locked", locked, 0);
        checkOutput("zero_stream_word_cnt", errWordCnt, 0);

        // Randomised traffic: gaps, drops, noise, injections, reloads and clears
        doReset();
        for (int i = 0; i < 2000; i++) begin
            bit               en, load, inj, clr, inV;
            logic [DW-1:0]    d;
            logic [POL_W-1:0] seed;
            en   = ($urandom % 8) != 0;
            load = ($urandom % 128) == 0;
            inj  = ($urandom % 16) == 0;
            clr  = ($urandom % 64) == 0;
            seed = 7'($urandom);
            inV  = mGenValid && (($urandom % 12) != 0);
            d    = inV ? mGenData : 16'($urandom);
            if (inV && ($urandom % 25) == 0) d = d ^ 16'($urandom);
            applyStimulus(load, seed, en, inj, inV, d, clr);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
